// File: rtl/router_ingress_arbiter.sv
// rtl/router_ingress_arbiter.sv - wormhole round-robin ingress arbiter and shared buffer occupancy counter
//
// Shares one packet buffer write port among NUM_PORTS ingress ports. A
// round-robin winner is picked among ports presenting SOP, and the grant is
// held until the packet's EOP is accepted. Also owns the buffer occupancy
// counter.
//
// Optional feature: define ROUTER_ARB_TIMEOUT_EN to abort a lock whose owner
// has presented no flit for TIMEOUT cycles (pulses pkt_abort).
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_sop/in_eop      per-port flit valid and packet qualifiers
//   in_data                     per-port flit data, port i at [i*DATA_W +: DATA_W]
//   in_ready                    per-port accept (transfer on valid & ready)
//   wr_en, wr_data              shared buffer write strobe and flit
//   grant_id                    granted (IDLE) or locked (LOCKED) port index
//   rd_pop                      egress removed one flit this cycle
//   count, full, empty          buffer occupancy and registered flags
//   busy                        a packet currently holds the lock
//   pkt_abort                   one-cycle pulse on lock timeout abort
module router_ingress_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int CNT_W     = 7,
   parameter int TIMEOUT   = 16,
   localparam int PTR_W    = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        in_valid,
   input  logic [NUM_PORTS-1:0]        in_sop,
   input  logic [NUM_PORTS-1:0]        in_eop,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   output logic [NUM_PORTS-1:0]        in_ready,
   output logic                        wr_en,
   output logic [DATA_W-1:0]           wr_data,
   output logic [PTR_W-1:0]            grant_id,
   input  logic                        rd_pop,
   output logic [CNT_W-1:0]            count,
   output logic                        full,
   output logic                        empty,
   output logic                        busy,
   output logic                        pkt_abort
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Elaboration-time sanity check on the parameter set.
   if ((1 << CNT_W) <= DEPTH || TIMEOUT < 1) begin : g_bad_param
      $error("router_ingress_arbiter: CNT_W too small for DEPTH or TIMEOUT < 1");
   end

   logic [0:0]           state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     owner;
   logic [NUM_PORTS-1:0] elig;
   logic                 win_found;
   logic [PTR_W-1:0]     win_id;
   logic [PTR_W:0]       cand_w;
   logic [PTR_W-1:0]     cand;
   logic                 pop_eff;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 timeout_hit;

   // Round-robin search starting just after the last packet's port.
   always_comb begin
      elig      = in_valid & in_sop;
      win_found = 1'b0;
      win_id    = '0;
      cand_w    = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand_w = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (cand_w >= (PTR_W+1)'(NUM_PORTS))
            cand_w = cand_w - (PTR_W+1)'(NUM_PORTS);
         cand = cand_w[PTR_W-1:0];
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Grant outputs are combinational (zero-latency acceptance) and held
   // quiet while reset is asserted.
   always_comb begin
      in_ready = '0;
      wr_en    = 1'b0;
      grant_id = '0;
      if (rst_n) begin
         if (state == ST_IDLE) begin
            if (!full && win_found) begin
               in_ready[win_id] = 1'b1;
               wr_en            = 1'b1;
               grant_id         = win_id;
            end
         end else begin
            grant_id        = owner;
            in_ready[owner] = !full;
            wr_en           = in_valid[owner] & !full;
         end
      end
   end

   assign wr_data = rst_n ? in_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
   assign busy    = (state == ST_LOCKED);

   // Occupancy: wr_en is already blocked when full, so count cannot pass DEPTH.
   always_comb begin
      pop_eff = rd_pop & (count != '0);
      cnt_nxt = count;
      if (wr_en && !pop_eff)
         cnt_nxt = count + CNT_W'(1);
      else if (pop_eff && !wr_en)
         cnt_nxt = count - CNT_W'(1);
   end

`ifdef ROUTER_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   logic [STALL_W-1:0] stall_cnt;
   logic               abort_q;

   // Cycles blocked only by a full buffer are not the owner's fault.
   assign timeout_hit = (state == ST_LOCKED) && !in_valid[owner] && !full &&
                        (stall_cnt == STALL_W'(TIMEOUT - 1));
   assign pkt_abort   = abort_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         abort_q   <= 1'b0;
      end else begin
         abort_q <= timeout_hit;
         if (state != ST_LOCKED || in_valid[owner] || timeout_hit)
            stall_cnt <= '0;
         else if (!full)
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign pkt_abort   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         rr_ptr <= PTR_W'(NUM_PORTS - 1);
         owner  <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         count <= cnt_nxt;
         full  <= (cnt_nxt == CNT_W'(DEPTH));
         empty <= (cnt_nxt == '0);
         if (state == ST_IDLE) begin
            if (wr_en) begin
               if (in_eop[win_id]) begin
                  rr_ptr <= win_id;
               end else begin
                  state <= ST_LOCKED;
                  owner <= win_id;
               end
            end
         end else begin
            if (timeout_hit || (wr_en && in_eop[owner])) begin
               state  <= ST_IDLE;
               rr_ptr <= owner;
            end
         end
      end
   end

endmodule
